// File: rtl/util_fifo_if.sv
// Handshake bundle for util_fifo: write-enable/full side and read-enable/valid side.
// The FIFO takes the slave modport; producer/consumer logic takes the master modport.
interface util_fifo_if #(
  parameter int BYTE_WIDTH  = 1,
  parameter int COUNT_WIDTH = 8
);
  logic                    rd_en;
  logic                    rd_valid;
  logic [BYTE_WIDTH*8-1:0] rd_data;
  logic                    rd_empty;
  logic                    wr_en;
  logic                    wr_ack;
  logic [BYTE_WIDTH*8-1:0] wr_data;
  logic                    wr_full;
  logic [COUNT_WIDTH-1:0]  data_count;

  modport master (
    output rd_en, wr_en, wr_data,
    input  rd_valid, rd_data, rd_empty, wr_ack, wr_full, data_count
  );

  modport slave (
    input  rd_en, wr_en, wr_data,
    output rd_valid, rd_data, rd_empty, wr_ack, wr_full, data_count
  );
endinterface

// File: rtl/util_fifo.sv
// Single-clock FIFO with optional first-word-fall-through read, write ack and
// occupancy count. Full/empty come from an occupancy counter, not pointer compare.
module util_fifo #(
  parameter int    FIFO_DEPTH  = 256,
  parameter int    BYTE_WIDTH  = 1,
  parameter int    COUNT_WIDTH = 8,
  parameter int    FWFT        = 1,
  parameter int    COUNT_DELAY = 1,
  parameter int    COUNT_ENA   = 1,
  parameter int    DATA_ZERO   = 0,
  parameter int    ACK_ENA     = 1,
  parameter string RAM_TYPE    = "block"
) (
  input logic        clk,
  input logic        rst,
  util_fifo_if.slave bus
);

  localparam int DW = BYTE_WIDTH * 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] DEPTH_V = OW'(FIFO_DEPTH);
  localparam longint CNT_MAX = (longint'(1) << COUNT_WIDTH) - 1;

  typedef logic [DW-1:0] word_t;

  (* ram_style = RAM_TYPE *) word_t mem [FIFO_DEPTH];

  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [OW-1:0]          occ_q, occ_d;
  logic [OW-1:0]          ram_cnt_q, ram_cnt_d;
  word_t                  stg_data_q, out_data_q;
  logic                   stg_valid_q, stg_valid_d;
  logic                   out_valid_q, out_valid_d;
  logic                   wr_full_q, rd_empty_q, rd_empty_d, wr_ack_q;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_dly_q, cnt_d;
  logic                   wr_acc, pop, ram_rd, out_load;

  // FWFT keeps a two-deep read pipeline (RAM read register, then output
  // register) that refills as it drains, so back-to-back pops run at one word/clock.
  always_comb begin
    // NOTE: every combinational output gets a default on every path so no latch is inferred.
    wr_acc      = bus.wr_en && !wr_full_q;
    pop         = 1'b0;
    out_load    = 1'b0;
    ram_rd      = 1'b0;
    out_valid_d = 1'b0;
    stg_valid_d = 1'b0;
    if (FWFT != 0) begin
      pop         = bus.rd_en && out_valid_q;
      out_load    = stg_valid_q && (!out_valid_q || pop);
      ram_rd      = (ram_cnt_q != '0) && (!stg_valid_q || out_load);
      out_valid_d = out_load || (out_valid_q && !pop);
      stg_valid_d = ram_rd || (stg_valid_q && !out_load);
    end else begin
      pop         = bus.rd_en && !rd_empty_q;
      ram_rd      = pop;
      out_valid_d = pop;
    end
    occ_d      = occ_q + OW'(wr_acc) - OW'(pop);
    ram_cnt_d  = ram_cnt_q + OW'(wr_acc) - OW'(ram_rd);
    rd_empty_d = (FWFT != 0) ? !out_valid_d : (occ_d == '0);
    cnt_d      = (longint'(occ_q) > CNT_MAX) ? '1 : COUNT_WIDTH'(occ_q);
  end

  // NOTE: storage and the RAM read register carry no reset so they map onto RAM
  // primitives; validity is tracked by the reset-controlled flags below.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.wr_data;
    if (ram_rd) stg_data_q <= mem[rd_ptr_q];
  end

  // NOTE: all state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      ram_cnt_q   <= '0;
      stg_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wr_full_q   <= 1'b0;
      rd_empty_q  <= 1'b1;
      wr_ack_q    <= 1'b0;
      cnt_q       <= '0;
      cnt_dly_q   <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (ram_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      occ_q       <= occ_d;
      ram_cnt_q   <= ram_cnt_d;
      stg_valid_q <= stg_valid_d;
      out_valid_q <= out_valid_d;
      if (out_load)                out_data_q <= stg_data_q;
      else if ((FWFT == 0) && pop) out_data_q <= mem[rd_ptr_q];
      wr_full_q   <= (occ_d == DEPTH_V);
      rd_empty_q  <= rd_empty_d;
      wr_ack_q    <= (ACK_ENA != 0) && wr_acc;
      cnt_q       <= cnt_d;
      cnt_dly_q   <= cnt_q;
    end
  end

  assign bus.rd_valid   = out_valid_q;
  assign bus.rd_data    = ((DATA_ZERO != 0) && !out_valid_q) ? '0 : out_data_q;
  assign bus.rd_empty   = rd_empty_q;
  assign bus.wr_full    = wr_full_q;
  assign bus.wr_ack     = wr_ack_q;
  assign bus.data_count = (COUNT_ENA == 0) ? '0 : ((COUNT_DELAY != 0) ? cnt_dly_q : cnt_q);

endmodule

// File: tb/tb_util_fifo.sv
// Scoreboard bench for util_fifo with default parameters (256 x 8-bit, FWFT).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_util_fifo;

  localparam int DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  util_fifo_if #(.BYTE_WIDTH(1), .COUNT_WIDTH(8)) bus ();

  util_fifo #(
    .FIFO_DEPTH (DEPTH),
    .BYTE_WIDTH (1),
    .COUNT_WIDTH(8),
    .FWFT       (1),
    .COUNT_DELAY(1),
    .COUNT_ENA  (1),
    .DATA_ZERO  (0),
    .ACK_ENA    (1),
    .RAM_TYPE   ("block")
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of traffic; the scoreboard decides acceptance and expected data.
  task automatic cycle(input bit wr, input logic [7:0] d, input bit rd);
    bit         acc;
    bit         popped;
    logic [7:0] e;
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    acc    = wr && (sb.size() < DEPTH);
    popped = 1'b0;
    if (rd && (bus.rd_valid === 1'b1)) begin
      if (sb.size() == 0) begin
        check("valid_while_model_empty", 32'(bus.rd_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        popped = 1'b1;
        check("rd_data", 32'(bus.rd_data), 32'(e));
      end
    end
    check("full_and_empty", 32'(bus.wr_full & bus.rd_empty), 32'd0);
    @(posedge clk);
    #1;
    if (acc) sb.push_back(d);
    check("wr_ack", 32'(bus.wr_ack), 32'(acc));
    check("wr_full", 32'(bus.wr_full), 32'(sb.size() == DEPTH));
    if (popped && sb.size() == DEPTH - 1) check("full_clears", 32'(bus.wr_full), 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) begin
      bus.wr_en   = 1'($urandom_range(0, 1));
      bus.rd_en   = 1'($urandom_range(0, 1));
      bus.wr_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_empty", 32'(bus.rd_empty), 32'd1);
    check("rst_wr_full", 32'(bus.wr_full), 32'd0);
    check("rst_wr_ack", 32'(bus.wr_ack), 32'd0);
    check("rst_data_count", 32'(bus.data_count), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    rst         = 1'b0;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    sb.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nxt;
    bit         will_acc;
    bus.wr_en   = 1'b0;
    bus.rd_en   = 1'b0;
    bus.wr_data = '0;
    rst         = 1'b1;
    @(posedge clk);
    #1;
    do_reset(2);

    // Fill to full, then one extra write that must be dropped.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    check("full_after_fill", 32'(bus.wr_full), 32'd1);
    cycle(1'b1, 8'h00, 1'b0);
    check("drop_keeps_size", 32'(sb.size()), 32'(DEPTH));
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("count_saturated", 32'(bus.data_count), 32'd255);
    check("valid_when_full", 32'(bus.rd_valid), 32'd1);

    // Drain at one word per clock.
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_valid", 32'(bus.rd_valid), 32'd1);
      cycle(1'b0, 8'h00, 1'b1);
    end
    check("drained_valid", 32'(bus.rd_valid), 32'd0);
    check("drained_empty", 32'(bus.rd_empty), 32'd1);
    check("rd_data_hold", 32'(bus.rd_data), 32'hFF);

    // FWFT latency: write at edge N, valid after edge N+2.
    cycle(1'b1, 8'h5A, 1'b0);
    check("lat_n0_valid", 32'(bus.rd_valid), 32'd0);
    cycle(1'b0, 8'h00, 1'b0);
    check("lat_n1_valid", 32'(bus.rd_valid), 32'd0);
    cycle(1'b0, 8'h00, 1'b0);
    check("lat_n2_valid", 32'(bus.rd_valid), 32'd1);
    check("lat_n2_data", 32'(bus.rd_data), 32'h5A);
    check("lat_count", 32'(bus.data_count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check("lat_popped_valid", 32'(bus.rd_valid), 32'd0);
    check("lat_popped_empty", 32'(bus.rd_empty), 32'd1);

    // Simultaneous read and write at full: pop happens, write dropped.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("refull", 32'(bus.wr_full), 32'd1);
    cycle(1'b1, 8'hAA, 1'b1);
    check("simul_not_full", 32'(bus.wr_full), 32'd0);
    check("simul_size", 32'(sb.size()), 32'(DEPTH - 1));

    // Reset at half full, then the next write must come out first.
    for (int i = 0; i < 127; i++) cycle(1'b0, 8'h00, 1'b1);
    check("half_size", 32'(sb.size()), 32'd128);
    do_reset(1);
    cycle(1'b1, 8'hC3, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("head_after_rst_valid", 32'(bus.rd_valid), 32'd1);
    check("head_after_rst_data", 32'(bus.rd_data), 32'hC3);
    cycle(1'b0, 8'h00, 1'b1);

    // Random stress: write every other clock, read rate low then high.
    nxt = 8'h00;
    for (int i = 0; i < 30000; i++) begin
      bit wr;
      bit rd;
      wr       = (i % 2) == 0;
      rd       = $urandom_range(0, 3) < ((i < 15000) ? 1 : 3);
      will_acc = wr && (sb.size() < DEPTH);
      cycle(wr, nxt, rd);
      if (will_acc) nxt = nxt + 8'd1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/util_fifo.md
Name: util_fifo

Overview:
Single-clock synchronous FIFO with a write-enable/full interface and a read-enable/valid interface. First-word-fall-through (FWFT) is optional; acknowledge and occupancy-count outputs are optional. It is a generic buffering utility between streaming producers and consumers, and it infers block or distributed RAM.

Parameters:
FIFO_DEPTH, 256, number of words; power of 2, minimum 4.
BYTE_WIDTH, 1, data width in bytes; data width = BYTE_WIDTH*8.
COUNT_WIDTH, 8, width of data_count.
FWFT, 1, 1 = first-word-fall-through read; 0 = standard read.
COUNT_DELAY, 1, 1 = data_count delayed by one extra register stage.
COUNT_ENA, 1, 1 = data_count active; 0 = data_count tied to 0.
DATA_ZERO, 0, 1 = rd_data forced to 0 whenever rd_valid is low.
ACK_ENA, 1, 1 = wr_ack active; 0 = wr_ack tied to 0.
RAM_TYPE, "block", RAM inference style attribute ("block" or "distributed").

Ports:
clk  in  1  single clock for all logic.
rst  in  1  synchronous reset, active-high.
rd_en  in  1  read request / pop.
rd_valid  out  1  rd_data holds a valid word.
rd_data  out  BYTE_WIDTH*8  read word.
rd_empty  out  1  no word is available to read.
wr_en  in  1  write request.
wr_ack  out  1  previous-cycle write was accepted.
wr_data  in  BYTE_WIDTH*8  write word.
wr_full  out  1  FIFO full; writes are ignored.
data_count  out  COUNT_WIDTH  occupancy.

Behaviour:
- Reset (clk edge with rst=1):
  - Pointers and occupancy cleared.
  - rd_valid=0, rd_data=0, rd_empty=1, wr_full=0, wr_ack=0, data_count=0.
  - Stored contents are discarded. A mid-operation reset returns to the empty state on the same edge; rd_en and wr_en are ignored during that edge.
- Write: accepted when wr_en=1 and wr_full=0 at the edge.
  - wr_data is stored at the write pointer, which increments modulo FIFO_DEPTH.
  - wr_ack is 1 in the following cycle for an accepted write, else 0.
  - A write while full is dropped silently: no ack, no state change.
- Occupancy: counts all words held, including a word sitting in the FWFT output register.
  - wr_full=1 when occupancy == FIFO_DEPTH. wr_full is registered and updates on the edge that makes the FIFO full or non-full.
- FWFT=1:
  - The head word is presented on rd_data with rd_valid=1 without any request.
  - A word written into an empty FIFO at edge N gives rd_valid=1 after edge N+2.
  - A pop occurs when rd_en=1 and rd_valid=1. The next word, if present, appears immediately after that edge (back-to-back pops give 1 word/clock). Otherwise rd_valid drops.
  - rd_en with rd_valid=0 is ignored.
  - rd_empty = ~rd_valid.
- FWFT=0:
  - A read occurs when rd_en=1 and rd_empty=0.
  - rd_data and rd_valid=1 are registered one clock later. rd_valid is a one-cycle pulse per read.
  - rd_empty=1 when occupancy == 0.
  - rd_en while empty is ignored.
- rd_data when not valid:
  - DATA_ZERO=0: holds the last value.
  - DATA_ZERO=1: 0.
- Simultaneous read and write:
  - Both are allowed; occupancy is unchanged.
  - When full, the read proceeds and the write is dropped (wr_full is sampled before the edge).
  - When empty, the write proceeds and the read is ignored.
- Ordering: strict FIFO; no word is lost or duplicated except dropped writes while full.
- data_count:
  - COUNT_DELAY=0: occupancy registered one clock after the change.
  - COUNT_DELAY=1: two clocks after the change.
  - Saturates at 2^COUNT_WIDTH-1 if occupancy exceeds that (e.g. 256 reports 255 with COUNT_WIDTH=8).
- Pointer wrap: modulo FIFO_DEPTH. Full/empty are distinguished by the occupancy counter, not by pointer equality.

Test Plan:
- Reset: hold rst 2 clocks with random rd_en/wr_en -> rd_valid=0, rd_empty=1, wr_full=0, wr_ack=0, data_count=0, rd_data=0.
- Fill (defaults, rd_en=0): write 0..255 continuously -> wr_ack=1 for each; wr_full=1 after the 256th write; the 257th write (value 0x00) is dropped with wr_ack=0; data_count=255 saturated.
- Drain: from full, rd_en=1 continuously -> rd_data 0x00..0xFF in order, one per clock; wr_full=0 after the first pop; rd_valid=0 and rd_empty=1 after the 256th pop.
- FWFT latency: single write of 0x5A into empty FIFO at edge N -> rd_valid=1 and rd_data=0x5A after edge N+2; rd_en=1 pops it and rd_valid=0 next cycle.
- Random stress: wr_en toggling every clock, rd_en random, data incrementing while not full, 30k cycles -> read stream is a strictly incrementing 8-bit sequence with wrap 0xFF->0x00 and no gaps except dropped full-writes; wr_full and rd_empty are never both 1.
- Simultaneous and reset cases:
  - At full, rd_en=1 and wr_en=1 together -> one pop, write dropped, wr_full=0 next cycle.
  - rst asserted at half full -> empty next cycle; subsequent writes start at the head.
